muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit that sits between the register file read ports and the write-back path. It takes two operands from the register file (dataA/dataB) plus a destination index. After a multi-cycle shift-add or restoring-divide sequence it returns a 32-bit result with a one-cycle valid strobe. The valid strobe drives RegWrite, result drives WB_out, and rd_out drives addD.

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned F3_W  = 3;
  localparam int unsigned RD_W  = 5;
  localparam int unsigned CNT_W = 6;

  localparam logic [F3_W-1:0] MUL    = 3'd0;
  localparam logic [F3_W-1:0] MULH   = 3'd1;
  localparam logic [F3_W-1:0] MULHSU = 3'd2;
  localparam logic [F3_W-1:0] MULHU  = 3'd3;
  localparam logic [F3_W-1:0] DIV    = 3'd4;
  localparam logic [F3_W-1:0] DIVU   = 3'd5;
  localparam logic [F3_W-1:0] REM    = 3'd6;
  localparam logic [F3_W-1:0] REMU   = 3'd7;

  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operation context captured at start and held until completion.
  typedef struct packed {
    logic [F3_W-1:0] op;
    logic            neg_q;
    logic            neg_r;
    logic [RD_W-1:0] rd;
  } op_ctrl_t;

  function automatic logic a_is_signed(input logic [F3_W-1:0] f3);
    return (f3 == MULH) || (f3 == MULHSU) || (f3 == DIV) || (f3 == REM);
  endfunction

  function automatic logic b_is_signed(input logic [F3_W-1:0] f3);
    return (f3 == MULH) || (f3 == DIV) || (f3 == REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// share one 64-bit accumulator; one bit per cycle, registered result strobe.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int unsigned DW = 2 * XLEN;

  state_t           state, state_n;
  logic [DW-1:0]    acc, acc_n;
  logic [XLEN-1:0]  opnd, opnd_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  op_ctrl_t         ctrl, ctrl_n;
  logic             res_load;

  logic             a_sgn, b_sgn, is_div_in;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN:0]    mul_sum, div_trial;
  logic [DW-1:0]    prod;
  logic [XLEN-1:0]  quot, rem, res_sel;

  always_comb begin
    a_sgn     = a_is_signed(funct3) && opA[XLEN-1];
    b_sgn     = b_is_signed(funct3) && opB[XLEN-1];
    mag_a     = a_sgn ? -opA : opA;
    mag_b     = b_sgn ? -opB : opB;
    is_div_in = funct3[2];
    mul_sum   = {1'b0, acc[DW-1:XLEN]} + {1'b0, opnd};
    div_trial = acc[DW-1:XLEN-1] - {1'b0, opnd};
  end

  // Sign correction and result selection from the finished accumulator.
  always_comb begin
    prod = ctrl.neg_q ? -acc : acc;
    quot = ctrl.neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = ctrl.neg_r ? -acc[DW-1:XLEN] : acc[DW-1:XLEN];
    case (ctrl.op)
      MUL:                 res_sel = prod[XLEN-1:0];
      MULH, MULHSU, MULHU: res_sel = prod[DW-1:XLEN];
      DIV, DIVU:           res_sel = quot;
      default:             res_sel = rem;
    endcase
  end

  always_comb begin
    state_n  = state;
    acc_n    = acc;
    opnd_n   = opnd;
    cnt_n    = cnt;
    ctrl_n   = ctrl;
    res_load = 1'b0;
    case (state)
      IDLE: begin
        if (start && !kill) begin
          ctrl_n.op    = funct3;
          ctrl_n.neg_q = a_sgn ^ b_sgn;
          ctrl_n.neg_r = a_sgn;
          ctrl_n.rd    = rd_in;
          cnt_n        = '0;
          state_n      = CALC;
          // Fast-path results are staged so the DONE correction passes them through.
          if (is_div_in && (opB == '0)) begin
            acc_n        = {opA, DIV0_Q};
            ctrl_n.neg_q = 1'b0;
            ctrl_n.neg_r = 1'b0;
            state_n      = DONE;
          end else if (b_is_signed(funct3) && is_div_in &&
                       (opA == INT_MIN) && (opB == '1)) begin
            acc_n        = {XLEN'(0), INT_MIN};
            ctrl_n.neg_q = 1'b0;
            ctrl_n.neg_r = 1'b0;
            state_n      = DONE;
          end else if (is_div_in) begin
            acc_n  = {XLEN'(0), mag_a};
            opnd_n = mag_b;
          end else begin
            acc_n  = {XLEN'(0), mag_b};
            opnd_n = mag_a;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_n = IDLE;
        end else begin
          if (ctrl.op[2]) begin
            if (!div_trial[XLEN])
              acc_n = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
              acc_n = {acc[DW-2:0], 1'b0};
          end else begin
            if (acc[0])
              acc_n = {mul_sum, acc[XLEN-1:1]};
            else
              acc_n = {1'b0, acc[DW-1:1]};
          end
          cnt_n = cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1))
            state_n = DONE;
        end
      end
      DONE: begin
        // First DONE cycle loads the result; the second retires while valid is high.
        if (kill || valid)
          state_n = IDLE;
        else
          res_load = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      ctrl   <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      acc   <= acc_n;
      opnd  <= opnd_n;
      cnt   <= cnt_n;
      ctrl  <= ctrl_n;
      busy  <= (state_n != IDLE);
      valid <= res_load;
      if (res_load) begin
        result <= res_sel;
        rd_out <= ctrl.rd;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector scoreboard bench for muldiv_unit.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [4:0]  rd_in = '0;
  logic        kill = 1'b0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  rd_out;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .opA(opA), .opB(opB), .rd_in(rd_in), .kill(kill),
    .busy(busy), .valid(valid), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: pops the oldest expectation on every valid strobe.
  always @(negedge clk) begin
    if (valid) begin
      chk("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", result, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rd_out", 32'(rd_out), 32'(e.rd));
        chk("latency_cycle", cyc, e.due);
      end
    end
    prev_valid <= valid;
  end

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd);
    @(negedge clk);
    funct3 = f3; opA = a; opB = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opA   = $urandom;
    opB   = $urandom;
    rd_in = 5'($urandom);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int unsigned lat);
    exp_t e;
    send(f3, a, b, rd);
    e.res = res; e.rd = rd; e.due = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy && !valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input int unsigned lat);
    issue(f3, a, b, rd, res, lat);
    wait_idle();
  endtask

  initial begin
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 33);
    run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33);
    run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 33);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 33);
    run(3'd3, 32'h8000_0000, 32'd4,         5'd7,  32'h0000_0002, 33);
    run(3'd0, 32'h0001_0000, 32'h10,        5'd0,  32'h0010_0000, 33);
    run(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 33);
    run(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 33);
    run(3'd4, 32'd7,        32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 33);
    run(3'd6, 32'd7,        32'hFFFF_FFFE, 5'd11, 32'h0000_0001, 33);
    run(3'd5, 32'd100,      32'd7,         5'd12, 32'd14,        33);
    run(3'd7, 32'd100,      32'd7,         5'd13, 32'd2,         33);
    run(3'd5, 32'hFFFF_FFFF, 32'd1,         5'd14, 32'hFFFF_FFFF, 33);
    run(3'd5, 32'd5,        32'd0,         5'd15, 32'hFFFF_FFFF, 1);
    run(3'd6, 32'd5,        32'd0,         5'd16, 32'd5,         1);
    run(3'd7, 32'd5,        32'd0,         5'd17, 32'd5,         1);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 1);

    // Kill a multiply ten cycles in, then start a divide on the next cycle.
    send(3'd0, 32'd123, 32'd456, 5'd20);
    repeat (10) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    chk("kill_busy_low", 32'(busy), 32'd0);
    chk("kill_result_held", result, 32'h0000_0000);
    run(3'd5, 32'd9, 32'd3, 5'd21, 32'd3, 33);

    // Start pulsed while busy must be ignored and result must hold.
    issue(3'd5, 32'd100, 32'd7, 5'd22, 32'd14, 33);
    repeat (5) @(negedge clk);
    funct3 = 3'd0; opA = 32'd2; opB = 32'd3; rd_in = 5'd9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_hold_result", result, 32'd3);
    chk("busy_hold_rd", 32'(rd_out), 32'd21);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("busy_start_dropped", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a divide.
    issue(3'd4, 32'd1000, 32'd3, 5'd23, 32'd333, 33);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_rd_out", 32'(rd_out), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(3'd0, 32'd6, 32'd7, 5'd24, 32'd42, 33);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
